// File: rtl/sobel_frame_sched_if.sv
// sobel_frame_sched_if: job, memory, filter-pixel and filter-result signals of the frame sequencer
interface sobel_frame_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              i_start;
    logic [ADDR_W-1:0] i_src_base;
    logic [ADDR_W-1:0] i_dst_base;
    logic [CNT_W-1:0]  i_num_res;
    logic              o_active;
    logic              o_done;
    logic              o_rd_req;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              i_rd_gnt;
    logic              i_rd_vld;
    logic [DATA_W-1:0] i_rd_data;
    logic              o_rgb_vld;
    logic [DATA_W-1:0] o_rgb_data;
    logic              i_rgb_busy;
    logic              i_avg_vld;
    logic [DATA_W-1:0] i_avg_data;
    logic              o_avg_busy;
    logic              o_wr_req;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              i_wr_gnt;
    modport master (
        input  i_start, i_src_base, i_dst_base, i_num_res, i_rd_gnt, i_rd_vld, i_rd_data,
               i_rgb_busy, i_avg_vld, i_avg_data, i_wr_gnt,
        output o_active, o_done, o_rd_req, o_rd_addr, o_rgb_vld, o_rgb_data, o_avg_busy,
               o_wr_req, o_wr_addr, o_wr_data
    );
    modport slave (
        output i_start, i_src_base, i_dst_base, i_num_res, i_rd_gnt, i_rd_vld, i_rd_data,
               i_rgb_busy, i_avg_vld, i_avg_data, i_wr_gnt,
        input  o_active, o_done, o_rd_req, o_rd_addr, o_rgb_vld, o_rgb_data, o_avg_busy,
               o_wr_req, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/sobel_frame_sched.sv
// sobel_frame_sched: streams pixel groups from memory into the Sobel filter and writes each result back
module sobel_frame_sched #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int PIX_PER_RES = 9,
    parameter int CNT_W       = 16
) (
    input logic                 i_clk,
    input logic                 i_rst,
    sobel_frame_sched_if.master bus
);
    localparam int PW = $clog2(PIX_PER_RES + 1);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PUSH, WAIT_RES, WR, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  num_q, res_q;
    logic [PW-1:0]     pix_q;
    logic [DATA_W-1:0] pix_data_q, res_data_q;
    logic              active_q, done_q, rd_req_q, rgb_vld_q, wr_req_q, avg_busy_q;
    logic              rgb_xfer, last_pix, last_res;
    assign rgb_xfer = (state_q == PUSH) && !bus.i_rgb_busy;
    assign last_pix = pix_q == PW'(PIX_PER_RES - 1);
    assign last_res = res_q == num_q - CNT_W'(1);
    assign bus.o_active   = active_q;
    assign bus.o_done     = done_q;
    assign bus.o_rd_req   = rd_req_q;
    assign bus.o_rd_addr  = src_q;
    assign bus.o_rgb_vld  = rgb_vld_q;
    assign bus.o_rgb_data = pix_data_q;
    assign bus.o_avg_busy = avg_busy_q;
    assign bus.o_wr_req   = wr_req_q;
    assign bus.o_wr_addr  = dst_q;
    assign bus.o_wr_data  = res_data_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.i_start) state_d = (bus.i_num_res == '0) ? DONE : RD_REQ;
            RD_REQ:   if (bus.i_rd_gnt) state_d = RD_WAIT;
            RD_WAIT:  if (bus.i_rd_vld) state_d = PUSH;
            PUSH:     if (rgb_xfer) state_d = last_pix ? WAIT_RES : RD_REQ;
            WAIT_RES: if (bus.i_avg_vld) state_d = WR;
            WR:       if (bus.i_wr_gnt) state_d = last_res ? DONE : RD_REQ;
            default:  state_d = IDLE;
        endcase
    end
    // Handshake outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            num_q      <= '0;
            res_q      <= '0;
            pix_q      <= '0;
            pix_data_q <= '0;
            res_data_q <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rgb_vld_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            avg_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            active_q   <= state_d != IDLE;
            done_q     <= state_d == DONE;
            rd_req_q   <= state_d == RD_REQ;
            rgb_vld_q  <= state_d == PUSH;
            wr_req_q   <= state_d == WR;
            avg_busy_q <= state_d != WAIT_RES;
            if (state_q == IDLE && bus.i_start) begin
                src_q <= bus.i_src_base;
                dst_q <= bus.i_dst_base;
                num_q <= bus.i_num_res;
                res_q <= '0;
                pix_q <= '0;
            end
            if (state_q == RD_WAIT && bus.i_rd_vld) begin
                pix_data_q <= bus.i_rd_data;
                src_q      <= src_q + ADDR_W'(1);
            end
            if (rgb_xfer) pix_q <= last_pix ? '0 : pix_q + PW'(1);
            if (state_q == WAIT_RES && bus.i_avg_vld) res_data_q <= bus.i_avg_data;
            if (state_q == WR && bus.i_wr_gnt) begin
                dst_q <= dst_q + ADDR_W'(1);
                res_q <= res_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_sched.sv
// tb_sobel_frame_sched: randomized memory/filter environment with a queue-based job model
module tb_sobel_frame_sched;
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;
    sobel_frame_sched_if #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) bus ();
    sobel_frame_sched #(.DATA_W(32), .ADDR_W(16), .PIX_PER_RES(9), .CNT_W(16)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );
    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] mseed;
    int pct = 0, wr_delay = 0, stall_pix = -1, stall_len = 0, spur = 0;
    int rd_dcnt, wr_wcnt, rgb_n, grp_n, avg_cnt, stall_left, stab_err, hold_err;
    bit rd_pend, avg_pend, avg_xfer, rgb_hold, wr_hold;
    logic [15:0] rd_addr_p, wr_prev_a;
    logic [31:0] grp_sum, res_val, rgb_prev, wr_prev_d;
    logic [15:0] rd_log[$], wr_addr_log[$];
    logic [31:0] rgb_log[$], wr_data_log[$];
    int done_log[$];

    // Memory content is a fixed scramble of the address; a result is the plain sum of its group.
    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a, a ^ 16'hA5C3} ^ mseed;
    endfunction
    function automatic logic [31:0] exp_res(input logic [15:0] s, input int r);
        logic [31:0] acc = 0;
        for (int i = 0; i < 9; i++) acc += mem(16'(s + 9 * r + i));
        return acc;
    endfunction

    task automatic clear_logs();
        rd_log.delete(); rgb_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); done_log.delete();
        rgb_n = 0; grp_n = 0; grp_sum = 0; stall_left = stall_len; stab_err = 0; hold_err = 0;
    endtask

    initial forever @(posedge i_clk) cyc++;

    initial begin
        bus.i_rd_gnt = 0; bus.i_rd_vld = 0; bus.i_rd_data = 0; bus.i_rgb_busy = 0;
        bus.i_avg_vld = 0; bus.i_avg_data = 0; bus.i_wr_gnt = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                rd_pend = 0; avg_pend = 0; avg_xfer = 0; rgb_hold = 0; wr_hold = 0; wr_wcnt = 0;
                bus.i_rd_gnt = 0; bus.i_rd_vld = 0; bus.i_rgb_busy = 0; bus.i_avg_vld = 0; bus.i_wr_gnt = 0;
                continue;
            end
            bus.i_rd_vld = 0;
            bus.i_rd_data = $urandom;
            if (rd_pend) begin
                if (rd_dcnt == 0) begin
                    bus.i_rd_vld = 1; bus.i_rd_data = mem(rd_addr_p); rd_pend = 0;
                end else rd_dcnt--;
            end
            bus.i_rd_gnt = bus.o_rd_req && !rd_pend && int'($urandom_range(0, 99)) >= pct;
            if (bus.i_rd_gnt) begin
                rd_log.push_back(bus.o_rd_addr);
                rd_pend = 1; rd_addr_p = bus.o_rd_addr;
                rd_dcnt = pct > 0 ? int'($urandom_range(0, 2)) : 0;
            end
            if (avg_xfer) begin bus.i_avg_vld = 0; avg_xfer = 0; end
            if (!bus.i_avg_vld) bus.i_avg_data = $urandom;
            if (avg_pend) begin
                if (avg_cnt == 0) begin
                    bus.i_avg_vld = 1; bus.i_avg_data = res_val; avg_pend = 0;
                end else avg_cnt--;
            end
            avg_xfer = bus.i_avg_vld && !bus.o_avg_busy;
            bus.i_rgb_busy = 0;
            if (bus.o_rgb_vld) begin
                if (rgb_hold && bus.o_rgb_data !== rgb_prev) stab_err++;
                if (rgb_n == stall_pix && stall_left > 0) begin
                    bus.i_rgb_busy = 1; stall_left--;
                end else bus.i_rgb_busy = int'($urandom_range(0, 99)) < pct;
                if (!bus.i_rgb_busy) begin
                    rgb_log.push_back(bus.o_rgb_data);
                    rgb_n++; grp_sum += bus.o_rgb_data; grp_n++;
                    if (grp_n == 9) begin
                        res_val = grp_sum; grp_sum = 0; grp_n = 0; avg_pend = 1;
                        avg_cnt = pct > 0 ? int'($urandom_range(0, 3)) : 0;
                    end
                end
                rgb_hold = bus.i_rgb_busy; rgb_prev = bus.o_rgb_data;
            end else begin
                if (rgb_hold) stab_err++;
                rgb_hold = 0;
            end
            bus.i_wr_gnt = 0;
            if (bus.o_wr_req) begin
                if (wr_hold && (bus.o_wr_addr !== wr_prev_a || bus.o_wr_data !== wr_prev_d)) hold_err++;
                bus.i_wr_gnt = wr_wcnt >= wr_delay && int'($urandom_range(0, 99)) >= pct;
                if (bus.i_wr_gnt) begin
                    wr_addr_log.push_back(bus.o_wr_addr); wr_data_log.push_back(bus.o_wr_data);
                    wr_wcnt = 0; wr_hold = 0;
                end else begin
                    wr_wcnt++; wr_hold = 1; wr_prev_a = bus.o_wr_addr; wr_prev_d = bus.o_wr_data;
                end
            end else begin
                if (wr_hold) hold_err++;
                wr_hold = 0;
            end
            if (bus.o_done) done_log.push_back(cyc);
        end
    end

    // t is the cycle count when start is presented; o_done is seen after the latch edge plus the job time.
    task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, output int t);
        clear_logs();
        @(negedge i_clk);
        bus.i_start = 1; bus.i_src_base = s; bus.i_dst_base = d; bus.i_num_res = n; t = cyc;
        @(negedge i_clk);
        bus.i_start = 0; bus.i_src_base = 16'($urandom); bus.i_dst_base = 16'($urandom); bus.i_num_res = 16'($urandom);
        if (spur != 0) begin
            repeat (10) @(negedge i_clk);
            bus.i_start = 1; bus.i_src_base = 16'h1234; bus.i_dst_base = 16'h4321; bus.i_num_res = 16'd7;
            @(negedge i_clk);
            bus.i_start = 0;
        end
        for (int k = 0; k < 300 * int'(n) + 100 && done_log.size() == 0; k++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy} !== 6'b000001) begin
            errors++; $display("FAIL reset_flags: got %b exp 000001", {bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy});
        end
        checks++;
        if ({bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data, bus.o_rgb_data} !== 96'd0) begin
            errors++; $display("FAIL reset_data: got %h exp 0", {bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data, bus.o_rgb_data});
        end
        i_rst = 1;
        repeat (5) @(negedge i_clk);
        checks++;
        if ({bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy} !== 6'b000001) begin
            errors++; $display("FAIL idle_flags: got %b exp 000001", {bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy});
        end
    endtask

    task automatic test_single();
        int t, bad;
        pct = 0; wr_delay = 0; stall_len = 0; spur = 0;
        run_job(16'h0100, 16'h0200, 16'd1, t);
        bad = 0;
        for (int i = 0; i < 9; i++) if (rd_log.size() <= i || rd_log[i] !== 16'(16'h0100 + i)) bad++;
        checks++;
        if (bad != 0 || rd_log.size() != 9) begin errors++; $display("FAIL single_rd: %0d bad of %0d reads, exp 9 at 0100..0108", bad, rd_log.size()); end
        bad = 0;
        for (int i = 0; i < 9; i++) if (rgb_log.size() <= i || rgb_log[i] !== mem(16'(16'h0100 + i))) bad++;
        checks++;
        if (bad != 0 || rgb_log.size() != 9) begin errors++; $display("FAIL single_rgb: %0d bad of %0d pixels, exp 9", bad, rgb_log.size()); end
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 16'h0200 || wr_data_log[0] !== exp_res(16'h0100, 0)) begin
            errors++; $display("FAIL single_wr: %0d writes, first %h/%h, exp 1 write 0200/%h", wr_addr_log.size(),
                wr_addr_log.size() > 0 ? wr_addr_log[0] : 16'hx, wr_data_log.size() > 0 ? wr_data_log[0] : 32'hx, exp_res(16'h0100, 0));
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] - t != 30) begin
            errors++; $display("FAIL single_done: %0d pulses, latency %0d, exp 1 at 30", done_log.size(), done_log.size() > 0 ? done_log[0] - t : -1);
        end
    endtask

    task automatic test_backpressure();
        int t, bad;
        logic [15:0] s, d;
        s = 16'($urandom); d = 16'($urandom);
        pct = 0; wr_delay = 3; stall_pix = 4; stall_len = 5; spur = 0;
        run_job(s, d, 16'd2, t);
        checks++;
        if (stab_err != 0 || hold_err != 0) begin errors++; $display("FAIL bp_hold: rgb unstable %0d, wr unstable %0d, exp 0/0", stab_err, hold_err); end
        bad = 0;
        for (int i = 0; i < 18; i++) if (rgb_log.size() <= i || rgb_log[i] !== mem(16'(s + i))) bad++;
        checks++;
        if (bad != 0 || rgb_log.size() != 18) begin errors++; $display("FAIL bp_rgb: %0d bad of %0d pixels, exp 18", bad, rgb_log.size()); end
        bad = 0;
        for (int r = 0; r < 2; r++) if (wr_addr_log.size() <= r || wr_addr_log[r] !== 16'(d + r) || wr_data_log[r] !== exp_res(s, r)) bad++;
        checks++;
        if (bad != 0 || wr_addr_log.size() != 2) begin errors++; $display("FAIL bp_wr: %0d bad of %0d writes, exp 2", bad, wr_addr_log.size()); end
        checks++;
        if (done_log.size() != 1 || done_log[0] - t != 1 + 58 + 5 + 6) begin
            errors++; $display("FAIL bp_done: %0d pulses, latency %0d, exp 1 at 70", done_log.size(), done_log.size() > 0 ? done_log[0] - t : -1);
        end
        stall_pix = -1; stall_len = 0; wr_delay = 0;
    endtask

    task automatic test_zero();
        int t;
        pct = 0; spur = 0;
        clear_logs();
        @(negedge i_clk);
        bus.i_start = 1; bus.i_src_base = 16'h0010; bus.i_dst_base = 16'h0020; bus.i_num_res = 16'd0; t = cyc;
        @(negedge i_clk);
        checks++;
        if ({bus.o_active, bus.o_done} !== 2'b11) begin errors++; $display("FAIL zero_active: active/done %b exp 11", {bus.o_active, bus.o_done}); end
        bus.i_num_res = 16'd3;
        @(negedge i_clk);
        bus.i_start = 0;
        repeat (40) @(negedge i_clk);
        checks++;
        if (done_log.size() != 1 || done_log[0] - t != 1) begin
            errors++; $display("FAIL zero_done: %0d pulses, latency %0d, exp 1 at 1", done_log.size(), done_log.size() > 0 ? done_log[0] - t : -1);
        end
        checks++;
        if (rd_log.size() + rgb_log.size() + wr_addr_log.size() != 0 || bus.o_active !== 1'b0) begin
            errors++; $display("FAIL zero_quiet: rd %0d rgb %0d wr %0d active %b, exp none and 0", rd_log.size(), rgb_log.size(), wr_addr_log.size(), bus.o_active);
        end
    endtask

    task automatic test_wrap();
        int t, bad;
        logic [15:0] d;
        d = 16'($urandom);
        pct = 0; spur = 1;
        run_job(16'hFFFC, d, 16'd2, t);
        spur = 0;
        bad = 0;
        for (int i = 0; i < 18; i++) if (rd_log.size() <= i || rd_log[i] !== 16'(16'hFFFC + i)) bad++;
        checks++;
        if (bad != 0 || rd_log.size() != 18) begin errors++; $display("FAIL wrap_rd: %0d bad of %0d reads, exp 18 from FFFC", bad, rd_log.size()); end
        bad = 0;
        for (int r = 0; r < 2; r++) if (wr_addr_log.size() <= r || wr_addr_log[r] !== 16'(d + r) || wr_data_log[r] !== exp_res(16'hFFFC, r)) bad++;
        checks++;
        if (bad != 0 || wr_addr_log.size() != 2) begin errors++; $display("FAIL wrap_wr: %0d bad of %0d writes, exp 2", bad, wr_addr_log.size()); end
        checks++;
        if (done_log.size() != 1 || done_log[0] - t != 59) begin
            errors++; $display("FAIL wrap_done: %0d pulses, latency %0d, exp 1 at 59", done_log.size(), done_log.size() > 0 ? done_log[0] - t : -1);
        end
    endtask

    task automatic test_reset_mid();
        int t, k;
        pct = 0; spur = 0;
        clear_logs();
        @(negedge i_clk);
        bus.i_start = 1; bus.i_src_base = 16'h0040; bus.i_dst_base = 16'h0300; bus.i_num_res = 16'd2;
        @(negedge i_clk);
        bus.i_start = 0;
        for (k = 0; k < 400 && !(rgb_log.size() >= 4 && bus.o_rgb_vld); k++) @(negedge i_clk);
        checks++;
        if (bus.o_rgb_vld !== 1'b1) begin errors++; $display("FAIL mid_reach: rgb_vld %b exp 1 after %0d cycles", bus.o_rgb_vld, k); end
        i_rst = 0;
        #1;
        checks++;
        if ({bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy} !== 6'b000001) begin
            errors++; $display("FAIL mid_flags: got %b exp 000001", {bus.o_active, bus.o_done, bus.o_rd_req, bus.o_rgb_vld, bus.o_wr_req, bus.o_avg_busy});
        end
        checks++;
        if ({bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data, bus.o_rgb_data} !== 96'd0) begin
            errors++; $display("FAIL mid_data: got %h exp 0", {bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data, bus.o_rgb_data});
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (done_log.size() != 0 || wr_addr_log.size() != 0) begin errors++; $display("FAIL mid_abort: %0d done, %0d writes, exp 0/0", done_log.size(), wr_addr_log.size()); end
        i_rst = 1;
        run_job(16'h0500, 16'h0600, 16'd1, t);
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 16'h0600 || wr_data_log[0] !== exp_res(16'h0500, 0) || done_log.size() != 1 || done_log[0] - t != 30) begin
            errors++; $display("FAIL mid_rerun: %0d writes, %0d done, exp 1 write 0600/%h and done at 30", wr_addr_log.size(), done_log.size(), exp_res(16'h0500, 0));
        end
    endtask

    task automatic test_random();
        int t, bad;
        logic [15:0] s, d, n;
        pct = 25; wr_delay = 0; spur = 0;
        for (int j = 0; j < 3; j++) begin
            s = 16'($urandom); d = 16'($urandom); n = 16'($urandom_range(1, 3));
            run_job(s, d, n, t);
            bad = 0;
            for (int i = 0; i < 9 * int'(n); i++) if (rgb_log.size() <= i || rgb_log[i] !== mem(16'(s + i)) || rd_log[i] !== 16'(s + i)) bad++;
            checks++;
            if (bad != 0 || rgb_log.size() != 9 * int'(n) || rd_log.size() != 9 * int'(n)) begin
                errors++; $display("FAIL rand_stream[%0d]: %0d bad, %0d rd %0d rgb, exp %0d", j, bad, rd_log.size(), rgb_log.size(), 9 * int'(n));
            end
            bad = 0;
            for (int r = 0; r < int'(n); r++) if (wr_addr_log.size() <= r || wr_addr_log[r] !== 16'(d + r) || wr_data_log[r] !== exp_res(s, r)) bad++;
            checks++;
            if (bad != 0 || wr_addr_log.size() != int'(n) || done_log.size() != 1 || stab_err + hold_err != 0) begin
                errors++; $display("FAIL rand_wr[%0d]: %0d bad of %0d writes, %0d done, unstable %0d, exp %0d writes 1 done 0 unstable",
                    j, bad, wr_addr_log.size(), done_log.size(), stab_err + hold_err, n);
            end
        end
        pct = 0;
    endtask

    initial begin
        mseed = $urandom;
        bus.i_start = 0; bus.i_src_base = 0; bus.i_dst_base = 0; bus.i_num_res = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
